// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter that shares one fpu_adder between NUM_REQ requesters, one operation at a time.
// Optional watchdog abort is compiled in with `define FPU_ARB_TIMEOUT_EN.
module fpu_add_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TMO_CYCLES = 511
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_z,
  output logic                   resp_err,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_a_stb,
  output logic                   add_b_stb,
  input  logic [31:0]            add_z,
  input  logic                   add_z_stb,
  output logic                   add_rst
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pick, cand;
  logic             found;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      z_q, z_d;
  logic             stb_q, stb_d;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int          CNT_W = $clog2(TMO_CYCLES + 1);
  localparam logic [31:0] QNAN  = 32'h7FC00000;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
`endif

  // Search starts one past the last requester served, wrapping at NUM_REQ.
  always_comb begin
    pick  = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    stb_d     = stb_q;
    req_ready = '0;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
    tmo_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          idx_d           = pick;
          a_d             = req_a[32*pick +: 32];
          b_d             = req_b[32*pick +: 32];
          stb_d           = 1'b1;
          state_d         = ISSUE;
`ifdef FPU_ARB_TIMEOUT_EN
          cnt_d           = '0;
          err_d           = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (add_z_stb) begin
          z_d     = add_z;
          stb_d   = 1'b0;
          state_d = RESP;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TMO_CYCLES - 1)) begin
          z_d     = QNAN;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          stb_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A grant must not be signalled in a cycle whose state update reset will discard.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      stb_q   <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      z_q     <= z_d;
    end
    a_q <= a_d;
    b_q <= b_d;
  end

`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end

  assign resp_err = (state_q == RESP) & err_q;
  assign add_rst  = rst | tmo_q;
`else
  assign resp_err = 1'b0;
  assign add_rst  = rst;
`endif

  always_comb begin
    resp_valid = '0;
    if (state_q == RESP) resp_valid[idx_q] = 1'b1;
  end

  assign resp_z    = (state_q == RESP) ? z_q : 32'h0;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_a_stb = stb_q;
  assign add_b_stb = stb_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: stub adder with programmable latency, grant/response scoreboards.
module tb_fpu_add_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic [31:0]     resp_z, add_a, add_b, add_z;
  logic            resp_err, add_a_stb, add_b_stb, add_z_stb, add_rst;

  fpu_add_arbiter #(.NUM_REQ(N), .TMO_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_z(resp_z), .resp_err(resp_err),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_rst(add_rst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {int idx; logic [31:0] z; logic err;} exp_t;
  exp_t sq[$];
  int   gq[$];

  // Stub adder: responds lat cycles after strobes rise, unless stalled.
  int          lat = 3;
  bit          stall = 1'b0;
  bit          spur = 1'b0;
  int          st_cnt = 0;
  bit          st_done = 1'b0;
  logic        st_stb = 1'b0;
  logic [31:0] st_z = '0;

  function automatic logic [31:0] sum_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      {32'hC0A00000, 32'h40A00000}: return 32'h00000000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    st_stb <= 1'b0;
    if (add_rst) begin
      st_cnt  <= 0;
      st_done <= 1'b0;
    end else if (add_a_stb && add_b_stb && !st_done && !stall) begin
      if (st_cnt >= lat - 1) begin
        st_stb  <= 1'b1;
        st_z    <= sum_fn(add_a, add_b);
        st_done <= 1'b1;
        st_cnt  <= 0;
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end else if (!add_a_stb) begin
      st_done <= 1'b0;
    end
  end

  assign add_z_stb = st_stb | spur;
  assign add_z     = spur ? 32'h12345678 : st_z;

  // Scoreboard monitor: every grant and response must match the head of its queue.
  always @(negedge clk) begin
    if (req_ready !== '0) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: req_ready=%b, none expected", req_ready);
      end else begin
        int eg;
        eg = gq.pop_front();
        if (req_ready !== N'(1 << eg)) begin
          errors++;
          $display("FAIL grant_order: req_ready=%b expected=%b", req_ready, N'(1 << eg));
        end
      end
    end
    if (resp_valid !== '0) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: resp_valid=%b, none expected", resp_valid);
      end else begin
        exp_t e;
        e = sq.pop_front();
        if (resp_valid !== N'(1 << e.idx) || resp_z !== e.z || resp_err !== e.err) begin
          errors++;
          $display("FAIL resp: valid=%b z=%h err=%b expected valid=%b z=%h err=%b",
                   resp_valid, resp_z, resp_err, N'(1 << e.idx), e.z, e.err);
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic push_op(input int i, input logic [31:0] z, input logic err);
    exp_t e;
    e.idx = i; e.z = z; e.err = err;
    gq.push_back(i);
    sq.push_back(e);
  endtask

  // Raise mask, wait for ngrants grant pulses; optionally drop each requester once granted.
  task automatic issue(input logic [N-1:0] mask, input int ngrants, input bit drop);
    int got = 0;
    int cyc = 0;
    logic [N-1:0] g;
    @(posedge clk); #1;
    req_valid = mask;
    while (got < ngrants && cyc < 200) begin
      @(negedge clk);
      g = req_ready;
      if (g !== '0) got++;
      @(posedge clk); #1;
      if (drop) req_valid = req_valid & ~g;
      cyc++;
    end
    req_valid = '0;
    checks++;
    if (got != ngrants) begin
      errors++;
      $display("FAIL grant_timeout: grants=%0d expected=%0d", got, ngrants);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sq.size() != 0 || gq.size() != 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending resp=%0d grants=%0d expected 0", sq.size(), gq.size());
      sq.delete();
      gq.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== '0 || resp_valid !== '0 || resp_z !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b z=%h err=%b expected all 0",
               req_ready, resp_valid, resp_z, resp_err);
    end
    checks++;
    if (add_a_stb !== 1'b0 || add_b_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: a_stb=%b b_stb=%b expected 0", add_a_stb, add_b_stb);
    end
    checks++;
    if (add_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_add_rst: add_rst=%b expected 1", add_rst);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (add_rst !== 1'b0) begin
      errors++;
      $display("FAIL release_add_rst: add_rst=%b expected 0", add_rst);
    end
  endtask

  task automatic test_single();
    set_ops(0, 32'h3F800000, 32'h40000000);
    push_op(0, 32'h40400000, 1'b0);
    issue(4'b0001, 1, 1'b1);
    @(negedge clk);
    checks++;
    if (add_a_stb !== 1'b1 || add_b_stb !== 1'b1 || add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin
      errors++;
      $display("FAIL issue_operands: stb=%b%b a=%h b=%h expected 11 3f800000 40000000",
               add_a_stb, add_b_stb, add_a, add_b);
    end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    set_ops(0, 32'h3F800000, 32'h40000000);
    set_ops(1, 32'h3F800000, 32'h3F800000);
    set_ops(2, 32'h40000000, 32'h40000000);
    set_ops(3, 32'h40400000, 32'h3F800000);
    push_op(0, 32'h40400000, 1'b0);
    push_op(1, 32'h40000000, 1'b0);
    push_op(2, 32'h40800000, 1'b0);
    push_op(3, 32'h40800000, 1'b0);
    push_op(0, 32'h40400000, 1'b0);
    issue(4'b1111, 5, 1'b0);
    drain();
  endtask

  task automatic test_zero_and_lost();
    set_ops(2, 32'hC0A00000, 32'h40A00000);
    set_ops(1, 32'h3F800000, 32'h3F800000);
    push_op(2, 32'h00000000, 1'b0);
    issue(4'b0100, 1, 1'b1);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    drain();
  endtask

  task automatic test_wrap();
    set_ops(3, 32'h40400000, 32'h3F800000);
    push_op(3, 32'h40800000, 1'b0);
    issue(4'b1000, 1, 1'b1);
    drain();
    set_ops(0, 32'h3F800000, 32'h40000000);
    set_ops(2, 32'h40000000, 32'h40000000);
    push_op(0, 32'h40400000, 1'b0);
    push_op(2, 32'h40800000, 1'b0);
    issue(4'b0101, 2, 1'b1);
    drain();
  endtask

  task automatic test_rst_mid_issue();
    lat = 6;
    set_ops(1, 32'h3F800000, 32'h3F800000);
    gq.push_back(1);
    issue(4'b0010, 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (add_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_add_rst: add_rst=%b expected 1", add_rst);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (add_a_stb !== 1'b0 || add_b_stb !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobes: a_stb=%b b_stb=%b expected 0", add_a_stb, add_b_stb);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== '0) begin
        errors++;
        $display("FAIL abort_no_resp: resp_valid=%b expected 0", resp_valid);
      end
    end
    lat = 3;
    set_ops(0, 32'h3F800000, 32'h40000000);
    push_op(0, 32'h40400000, 1'b0);
    issue(4'b0001, 1, 1'b1);
    drain();
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== '0 || add_a_stb !== 1'b0) begin
        errors++;
        $display("FAIL spurious_idle: resp_valid=%b a_stb=%b expected 0 0", resp_valid, add_a_stb);
      end
    end
    set_ops(2, 32'hC0A00000, 32'h40A00000);
    push_op(2, 32'h00000000, 1'b0);
    issue(4'b0100, 1, 1'b1);
    drain();
  endtask

`ifdef FPU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int stb_cyc = 0;
    int rst_pulses = 0;
    stall = 1'b1;
    set_ops(0, 32'h3F800000, 32'h40000000);
    gq.push_back(0);
    begin
      exp_t e;
      e.idx = 0; e.z = 32'h7FC00000; e.err = 1'b1;
      sq.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (add_a_stb) stb_cyc++;
      if (add_rst) rst_pulses++;
    end
    stall = 1'b0;
    checks++;
    if (stb_cyc != 16) begin
      errors++;
      $display("FAIL timeout_issue_cycles: got=%0d expected=16", stb_cyc);
    end
    checks++;
    if (rst_pulses != 1) begin
      errors++;
      $display("FAIL timeout_add_rst: pulses=%0d expected=1", rst_pulses);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_and_lost();
    test_wrap();
    test_rst_mid_issue();
    test_spurious();
`ifdef FPU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
